// File: rtl/mmu_xlat.sv
// 8722-style MMU register file with a registered one-clock address translation stage.
// Define MMU_PAGE_SWAP_EN to enable the reverse page-swap translation path.
module mmu_xlat #(
    parameter int          NUM_PCR  = 4,
    parameter int          NUM_PAGE = 2,
    parameter int          BANK_W   = 2,
    parameter logic [15:0] IO_BASE  = 16'hD500,
    parameter logic [15:0] LCR_BASE = 16'hFF00,
    parameter logic [7:0]  VERSION  = 8'h20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req,
    input  logic              rw,
    input  logic [15:0]       addr,
    input  logic [7:0]        d_in,
    output logic [7:0]        d_out,
    output logic              d_oe,
    input  logic              k4080,
    output logic              os,
    output logic [7:0]        t_addr,
    output logic [BANK_W-1:0] t_bank,
    output logic              t_valid
);

    localparam int          NUM_REG = NUM_PCR + 4 + 2 * NUM_PAGE;
    localparam logic [15:0] K_MCR   = 16'(NUM_PCR + 1);
    localparam logic [15:0] K_RCR   = 16'(NUM_PCR + 2);
    localparam logic [15:0] K_PG    = 16'(NUM_PCR + 3);
    localparam logic [15:0] K_VER   = 16'(NUM_REG - 1);

    logic [7:0]  r_cr;
    logic [7:0]  r_pcr [NUM_PCR];
    logic        r_cpu, r_fsdir, r_game, r_exrom, r_os;
    logic [1:0]  r_rcr_size, r_vicbank;
    logic        r_rcr_low, r_rcr_high;
    logic [11:0] r_page [NUM_PAGE];
    logic [3:0]  r_stage [NUM_PAGE];

    logic [15:0]       w_io_off, w_lcr_off;
    logic              w_io_hit, w_lcr_hit, w_io_wr, w_lcr_wr;
    logic [7:0]        w_io_val, w_lcr_val, w_lcr_wval;
    logic [7:0]        w_hi, w_cmn_pages;
    logic [BANK_W-1:0] w_cr_bank;
    logic              w_reloc_hit, w_swap_hit, w_cmn_hit;
    logic [7:0]        w_reloc_addr, w_swap_addr, w_nx_addr;
    logic [BANK_W-1:0] w_reloc_bank, w_nx_bank;

    assign os = r_os;

    // With os set the I/O window disappears entirely; the LCR window stays live.
    assign w_io_off  = addr - IO_BASE;
    assign w_lcr_off = addr - LCR_BASE;
    assign w_io_hit  = req && (addr >= IO_BASE) && (w_io_off < 16'(NUM_REG)) && !r_os;
    assign w_lcr_hit = req && (addr >= LCR_BASE) && (w_lcr_off <= 16'(NUM_PCR));
    assign w_io_wr   = w_io_hit && !rw;
    assign w_lcr_wr  = w_lcr_hit && !rw && !w_io_hit;
    assign d_oe      = rw && (w_io_hit || w_lcr_hit);

    // Register read multiplexers for both windows and the LCR write value.
    always_comb begin
        w_io_val  = 8'h00;
        w_lcr_val = r_cr;
        w_io_val  = (w_io_off == 16'd0) ? r_cr : w_io_val;
        for (int i = 0; i < NUM_PCR; i++) begin
            w_io_val  = (w_io_off == 16'(i + 1)) ? r_pcr[i] : w_io_val;
            w_lcr_val = (w_lcr_off == 16'(i + 1)) ? r_pcr[i] : w_lcr_val;
        end
        w_io_val = (w_io_off == K_MCR) ?
                   {k4080, r_os, r_exrom, r_game, r_fsdir, 2'b00, r_cpu} : w_io_val;
        w_io_val = (w_io_off == K_RCR) ?
                   {r_vicbank, 2'b00, r_rcr_high, r_rcr_low, r_rcr_size} : w_io_val;
        for (int p = 0; p < NUM_PAGE; p++) begin
            w_io_val = (w_io_off == K_PG + 16'(2 * p)) ? r_page[p][7:0] : w_io_val;
            w_io_val = (w_io_off == K_PG + 16'(2 * p + 1)) ? {4'h0, r_page[p][11:8]} : w_io_val;
        end
        w_io_val   = (w_io_off == K_VER) ? VERSION : w_io_val;
        w_lcr_wval = (w_lcr_off == 16'd0) ? d_in : w_lcr_val;
        if (w_io_hit && rw) begin
            d_out = w_io_val;
        end else if (w_lcr_hit && rw) begin
            d_out = w_lcr_val;
        end else begin
            d_out = 8'h00;
        end
    end

    // Next translation: relocation beats swap beats common RAM beats CR bank.
    always_comb begin
        w_hi         = addr[15:8];
        w_cr_bank    = BANK_W'(r_cr[7:6]);
        w_reloc_hit  = 1'b0;
        w_reloc_addr = 8'h00;
        w_reloc_bank = '0;
        w_swap_hit   = 1'b0;
        w_swap_addr  = 8'h00;
        for (int p = 0; p < NUM_PAGE; p++) begin
            w_reloc_addr = (w_hi == 8'(p)) ? r_page[p][7:0] : w_reloc_addr;
            w_reloc_bank = (w_hi == 8'(p)) ? r_page[p][BANK_W+7:8] : w_reloc_bank;
            w_reloc_hit  = w_reloc_hit || (w_hi == 8'(p));
        end
`ifdef MMU_PAGE_SWAP_EN
        for (int p = NUM_PAGE - 1; p >= 0; p--) begin
            w_swap_addr = ((w_hi == r_page[p][7:0]) && (r_page[p][BANK_W+7:8] == w_cr_bank) &&
                           (r_page[p][7:0] != 8'(p))) ? 8'(p) : w_swap_addr;
            w_swap_hit  = w_swap_hit || ((w_hi == r_page[p][7:0]) &&
                          (r_page[p][BANK_W+7:8] == w_cr_bank) && (r_page[p][7:0] != 8'(p)));
        end
`endif
        case (r_rcr_size)
            2'b00:   w_cmn_pages = 8'd4;
            2'b01:   w_cmn_pages = 8'd16;
            2'b10:   w_cmn_pages = 8'd32;
            default: w_cmn_pages = 8'd64;
        endcase
        w_cmn_hit = (r_rcr_low && (w_hi < w_cmn_pages)) ||
                    (r_rcr_high && (w_hi >= (8'd0 - w_cmn_pages)));
        if (w_reloc_hit) begin
            w_nx_addr = w_reloc_addr;
            w_nx_bank = w_reloc_bank;
        end else if (w_swap_hit) begin
            w_nx_addr = w_swap_addr;
            w_nx_bank = w_cr_bank;
        end else if (w_cmn_hit) begin
            w_nx_addr = w_hi;
            w_nx_bank = '0;
        end else begin
            w_nx_addr = w_hi;
            w_nx_bank = w_cr_bank;
        end
    end

    // Register file writes; a high page write only stages its nibble until the low write.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cr       <= 8'h00;
            r_cpu      <= 1'b0;
            r_os       <= 1'b0;
            r_fsdir    <= 1'b1;
            r_game     <= 1'b1;
            r_exrom    <= 1'b1;
            r_rcr_size <= 2'b00;
            r_rcr_low  <= 1'b0;
            r_rcr_high <= 1'b0;
            r_vicbank  <= 2'b00;
            for (int i = 0; i < NUM_PCR; i++) r_pcr[i] <= 8'h00;
            for (int p = 0; p < NUM_PAGE; p++) begin
                r_page[p]  <= 12'(p);
                r_stage[p] <= 4'h0;
            end
        end else if (w_io_wr) begin
            if (w_io_off == 16'd0) r_cr <= d_in;
            for (int i = 0; i < NUM_PCR; i++) begin
                if (w_io_off == 16'(i + 1)) r_pcr[i] <= d_in;
            end
            if (w_io_off == K_MCR) begin
                r_cpu   <= d_in[0];
                r_fsdir <= d_in[3];
                r_game  <= d_in[4];
                r_exrom <= d_in[5];
                r_os    <= d_in[6];
            end
            if (w_io_off == K_RCR) begin
                r_rcr_size <= d_in[1:0];
                r_rcr_low  <= d_in[2];
                r_rcr_high <= d_in[3];
                r_vicbank  <= d_in[7:6];
            end
            for (int p = 0; p < NUM_PAGE; p++) begin
                if (w_io_off == K_PG + 16'(2 * p)) r_page[p] <= {r_stage[p], d_in};
                if (w_io_off == K_PG + 16'(2 * p + 1)) r_stage[p] <= d_in[3:0];
            end
        end else if (w_lcr_wr) begin
            r_cr <= w_lcr_wval;
        end
    end

    // Translation output stage: valid follows req, address/bank hold while idle.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_valid <= 1'b0;
            t_addr  <= 8'h00;
            t_bank  <= '0;
        end else begin
            t_valid <= req;
            if (req) begin
                t_addr <= w_nx_addr;
                t_bank <= w_nx_bank;
            end
        end
    end

endmodule

// File: tb/tb_mmu_xlat.sv
// Table-driven bench for mmu_xlat: register map, staged page writes, LCR, os hiding, translation.
module tb_mmu_xlat;

`ifdef MMU_PAGE_SWAP_EN
    localparam bit SWAP = 1'b1;
`else
    localparam bit SWAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        req = 1'b0;
    logic        rw = 1'b1;
    logic [15:0] addr = 16'h0000;
    logic [7:0]  d_in = 8'h00;
    logic [7:0]  d_out;
    logic        d_oe;
    logic        k4080 = 1'b1;
    logic        os;
    logic [7:0]  t_addr;
    logic [1:0]  t_bank;
    logic        t_valid;

    int total = 0;
    int bad   = 0;

    mmu_xlat dut (
        .clk(clk), .reset_n(reset_n), .req(req), .rw(rw), .addr(addr), .d_in(d_in),
        .d_out(d_out), .d_oe(d_oe), .k4080(k4080), .os(os),
        .t_addr(t_addr), .t_bank(t_bank), .t_valid(t_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rs;
        bit          rq;
        bit          rw;
        logic [15:0] a;
        logic [7:0]  d;
        bit          crd;
        bit          eoe;
        logic [7:0]  edo;
        bit          eos;
        bit          ct;
        logic [7:0]  eta;
        logic [1:0]  etb;
        bit          etv;
        string       nm;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(bit rs, bit rq, bit rwv, logic [15:0] a, logic [7:0] d,
                                bit crd, bit eoe, logic [7:0] edo, bit eos,
                                bit ct, logic [7:0] eta, logic [1:0] etb, bit etv, string nm);
        vec_t v;
        v.rs = rs; v.rq = rq; v.rw = rwv; v.a = a; v.d = d;
        v.crd = crd; v.eoe = eoe; v.edo = edo; v.eos = eos;
        v.ct = ct; v.eta = eta; v.etb = etb; v.etv = etv; v.nm = nm;
        return v;
    endfunction

    function automatic vec_t rd(logic [15:0] a, bit eoe, logic [7:0] edo, bit eos, string nm);
        return mk(1'b0, 1'b1, 1'b1, a, 8'h00, 1'b1, eoe, edo, eos, 1'b0, 8'h00, 2'd0, 1'b0, nm);
    endfunction

    function automatic vec_t wr(logic [15:0] a, logic [7:0] d, string nm);
        return mk(1'b0, 1'b1, 1'b0, a, d, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 2'd0, 1'b0, nm);
    endfunction

    function automatic vec_t idl(logic [7:0] eta, logic [1:0] etb, bit etv, string nm);
        return mk(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, eta, etb, etv, nm);
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        req = 1'b0; rw = 1'b1; reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        reset_n = 1'b1;
    endtask

    logic [7:0] rst_exp [12];

    initial begin
        rst_exp = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hB8,
                    8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h20};
        for (int k = 0; k < 12; k++) begin
            tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'hD500 + 16'(k), 8'h00, 1'b1, 1'b1, rst_exp[k], 1'b0,
                             1'b1, (k == 0) ? 8'h00 : 8'hD5, 2'd0, (k == 0) ? 1'b0 : 1'b1,
                             $sformatf("rst_reg%0d", k)));
        end
        tbl.push_back(wr(16'hD508, 8'h03, "wr_pg0_hi"));
        tbl.push_back(rd(16'hD508, 1'b1, 8'h00, 1'b0, "pg0_hi_staged"));
        tbl.push_back(rd(16'hD507, 1'b1, 8'h00, 1'b0, "pg0_lo_old"));
        tbl.push_back(wr(16'hD507, 8'h40, "wr_pg0_lo"));
        tbl.push_back(rd(16'hD507, 1'b1, 8'h40, 1'b0, "pg0_lo_new"));
        tbl.push_back(rd(16'hD508, 1'b1, 8'h03, 1'b0, "pg0_hi_new"));
        tbl.push_back(rd(16'h0012, 1'b0, 8'h00, 1'b0, "rd_outside"));
        tbl.push_back(idl(8'h40, 2'd3, 1'b1, "xl_reloc"));
        tbl.push_back(idl(8'h40, 2'd3, 1'b0, "xl_hold"));
        tbl.push_back(wr(16'hD502, 8'hC0, "wr_pcr1"));
        tbl.push_back(wr(16'hFF02, 8'h55, "lcr_pcr1"));
        tbl.push_back(rd(16'hD500, 1'b1, 8'hC0, 1'b0, "cr_from_pcr"));
        tbl.push_back(rd(16'hFF00, 1'b1, 8'hC0, 1'b0, "lcr_rd0"));
        tbl.push_back(rd(16'hFF02, 1'b1, 8'hC0, 1'b0, "lcr_rd2"));
        tbl.push_back(rd(16'h8000, 1'b0, 8'h00, 1'b0, "rd_8000"));
        tbl.push_back(idl(8'h80, 2'd3, 1'b1, "xl_crbank"));
        tbl.push_back(rd(16'h4000, 1'b0, 8'h00, 1'b0, "rd_4000"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h0000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,
                         1'b1, SWAP ? 8'h00 : 8'h40, 2'd3, 1'b1, "xl_swap_b3"));
        tbl.push_back(idl(8'h40, 2'd3, 1'b1, "xl_reloc_pg0"));
        tbl.push_back(wr(16'hD505, 8'h40, "wr_mcr_os"));
        tbl.push_back(rd(16'hD505, 1'b0, 8'h00, 1'b1, "io_hidden"));
        tbl.push_back(wr(16'hD500, 8'h11, "wr_cr_hidden"));
        tbl.push_back(rd(16'hFF00, 1'b1, 8'hC0, 1'b1, "cr_unchanged"));
        tbl.push_back(wr(16'hFF00, 8'h22, "lcr_wr0"));
        tbl.push_back(rd(16'hFF00, 1'b1, 8'h22, 1'b1, "lcr_cr_new"));
        tbl.push_back(rd(16'hFF01, 1'b1, 8'h00, 1'b1, "lcr_pcr0"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'hD506, 8'h0A, 1'b0, 1'b0, 8'h00, 1'b0,
                         1'b0, 8'h00, 2'd0, 1'b0, "wr_rcr"));
        tbl.push_back(wr(16'hFF00, 8'h40, "lcr_cr40"));
        tbl.push_back(rd(16'hF000, 1'b0, 8'h00, 1'b0, "rd_f000"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'hB000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,
                         1'b1, 8'hF0, 2'd0, 1'b1, "xl_hi_common"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h4000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,
                         1'b1, 8'hB0, 2'd1, 1'b1, "xl_no_common"));
        tbl.push_back(idl(8'h40, 2'd1, 1'b1, "xl_lo_disabled"));
        tbl.push_back(wr(16'hD506, 8'h05, "wr_rcr_lo4k"));
        tbl.push_back(rd(16'h0F00, 1'b0, 8'h00, 1'b0, "rd_0f00"));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 16'h1000, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,
                         1'b1, 8'h0F, 2'd0, 1'b1, "xl_lo_edge_in"));
        tbl.push_back(idl(8'h10, 2'd1, 1'b1, "xl_lo_edge_out"));
        tbl.push_back(mk(1'b1, 1'b1, 1'b0, 16'hD508, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0,
                         1'b0, 8'h00, 2'd0, 1'b0, "swp_hi"));
        tbl.push_back(wr(16'hD507, 8'h40, "swp_lo"));
        tbl.push_back(rd(16'h4000, 1'b0, 8'h00, 1'b0, "swp_rd"));
        tbl.push_back(idl(SWAP ? 8'h00 : 8'h40, 2'd0, 1'b1, "xl_swap_b0"));

        do_reset();
        #1;
        chk("rst_t_valid", {7'd0, t_valid}, 8'h00);
        chk("rst_t_addr", t_addr, 8'h00);
        chk("rst_t_bank", {6'd0, t_bank}, 8'h00);
        chk("rst_os", {7'd0, os}, 8'h00);

        foreach (tbl[i]) begin
            if (tbl[i].rs) do_reset();
            @(posedge clk);
            req = tbl[i].rq; rw = tbl[i].rw; addr = tbl[i].a; d_in = tbl[i].d;
            #1;
            if (tbl[i].crd) begin
                chk({tbl[i].nm, "_oe"}, {7'd0, d_oe}, {7'd0, tbl[i].eoe});
                chk({tbl[i].nm, "_dout"}, d_out, tbl[i].edo);
                chk({tbl[i].nm, "_os"}, {7'd0, os}, {7'd0, tbl[i].eos});
            end
            if (tbl[i].ct) begin
                chk({tbl[i].nm, "_taddr"}, t_addr, tbl[i].eta);
                chk({tbl[i].nm, "_tbank"}, {6'd0, t_bank}, {6'd0, tbl[i].etb});
                chk({tbl[i].nm, "_tvalid"}, {7'd0, t_valid}, {7'd0, tbl[i].etv});
            end
        end

        // Reset in the middle of a burst, with a write pending for the next falling edge.
        @(posedge clk);
        req = 1'b1; rw = 1'b1; addr = 16'h1234;
        @(posedge clk);
        req = 1'b1; rw = 1'b0; addr = 16'hD500; d_in = 8'h77;
        #1;
        chk("burst_t_valid", {7'd0, t_valid}, 8'h01);
        chk("burst_t_addr", t_addr, 8'h12);
        reset_n = 1'b0;
        #1;
        chk("mid_rst_t_valid", {7'd0, t_valid}, 8'h00);
        chk("mid_rst_t_addr", t_addr, 8'h00);
        chk("mid_rst_t_bank", {6'd0, t_bank}, 8'h00);
        @(negedge clk);
        @(posedge clk);
        reset_n = 1'b1;
        req = 1'b1; rw = 1'b1; addr = 16'hD500;
        #1;
        chk("wr_discarded", d_out, 8'h00);
        chk("wr_discarded_oe", {7'd0, d_oe}, 8'h01);
        @(posedge clk);
        req = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
